flash_rom_ctrl: RTL
===================

Name: flash_rom_ctrl

Overview:
- Wishbone slave that sequences asynchronous reads of the board's 16-bit parallel NOR flash for the BIOS/shadow region.
- Replaces the fixed on-chip ROM path with real flash timing: a programmable wait-state counter and a bank register that extends the 16-bit word address to the flash's 22-bit word address.
- Two tiny config registers sit in I/O space, selected by wb_tga_i.
- Read-only to flash; writes to memory space are acknowledged and discarded.

Parameters:
WAIT_DEFAULT, 4, wait-state count loaded at reset (0..15)
BANK_DEFAULT, 0, flash bank (flash_addr_[21:16]) loaded at reset (0..63)

Ports:
wb_clk_i  input  1  system clock; one clock, all logic on its rising edge
wb_rst_i  input  1  reset; asynchronous and active-low
wb_dat_i  input  16  write data (config registers only)
wb_dat_o  output  16  read data, registered
wb_adr_i  input  19  word address [19:1]
wb_we_i  input  1  write enable
wb_tga_i  input  1  1 = config (I/O) space, 0 = flash memory space
wb_stb_i  input  1  strobe
wb_cyc_i  input  1  cycle
wb_sel_i  input  2  byte selects
wb_ack_o  output  1  acknowledge, registered, one-cycle pulse
flash_addr_  output  22  flash word address, registered
flash_data_  input  16  flash read data
flash_we_n_  output  1  flash write enable, constant 1 after reset
flash_oe_n_  output  1  flash output enable, active low
flash_ce_n_  output  1  flash chip enable, active low
flash_rst_n_  output  1  flash reset, active low

Behaviour:
- Reset (wb_rst_i=0, async):
  - wb_ack_o=0, wb_dat_o=0, flash_addr_=0.
  - flash_ce_n_=1, flash_oe_n_=1, flash_we_n_=1, flash_rst_n_=0.
  - wait_cfg=WAIT_DEFAULT, bank=BANK_DEFAULT, state=IDLE.
  - flash_rst_n_ goes 1 on the first clock edge after reset release.
- req = wb_stb_i & wb_cyc_i. The request is sampled only in IDLE.
- States: IDLE, SETUP, WAIT, ACK.
- IDLE:
  - req & tga=1 -> ACK.
    - Write: wait_cfg <= wb_dat_i[3:0] if wb_sel_i[0] (adr[1]=0); bank <= wb_dat_i[5:0] if wb_sel_i[0] (adr[1]=1).
    - Read: wb_dat_o <= {12'h0,wait_cfg} when adr[1]=0, {10'h0,bank} when adr[1]=1.
  - req & tga=0 & we=1 -> ACK. Flash untouched; wb_dat_o unchanged.
  - req & tga=0 & we=0 -> SETUP. Also flash_addr_ <= {bank, wb_adr_i[16:1]}; wb_adr_i[19:17] is ignored.
- SETUP:
  - flash_ce_n_=0, flash_oe_n_=0.
  - Wait counter loads wait_cfg.
  - Next state: WAIT if wait_cfg != 0, else ACK.
- WAIT:
  - ce_n/oe_n stay 0; counter decrements each cycle.
  - Leaves to ACK on the edge where the counter is 1, so WAIT lasts exactly wait_cfg cycles.
- Data capture: wb_dat_o <= flash_data_ on the edge that enters ACK from SETUP or WAIT.
- ACK:
  - wb_ack_o=1 for exactly one cycle; ce_n/oe_n=1.
  - Next state is unconditionally IDLE.
- Latency: with the request sampled at edge e0, wb_ack_o is high in the cycle after edge e(wait_cfg+1).
  - Flash read: wait_cfg+2 cycles total, counting the request cycle.
  - Config and ignored writes: ack in the cycle after e0.
- Back-to-back: a request still asserted in the cycle after ACK starts a new access from IDLE.
- Abort: if req drops in SETUP or WAIT, next edge -> IDLE.
  - No ack; ce_n/oe_n=1; wb_dat_o unchanged.
- A wait_cfg change takes effect on the next flash read, never on one in progress (the counter is loaded in SETUP).
- Reset mid-access: immediate return to reset values, no ack; flash_rst_n_ pulses low.
- wb_dat_o holds its last value between accesses.

Test Plan:
- Reset release, then read config adr[1]=0 -> wb_dat_o=0x0004, ack 1 cycle after sampling; flash_rst_n_=1 one edge after release.
- Flash read, wait_cfg=4, bank=0, adr word 0x0FFF8, flash_data_=0xEA5B:
  - flash_addr_=0x00FFF8, ce_n/oe_n low 5 cycles.
  - wb_dat_o=0xEA5B with a single-cycle ack 6 cycles after the request cycle.
- Write 0x0000 to wait reg and 0x0003 to bank reg, then read word 0x01234:
  - flash_addr_=0x031234.
  - ack on the 2nd cycle after the request cycle (0-wait path, SETUP->ACK).
- Write to memory space (tga=0, we=1, data 0xFFFF): ack after 1 cycle; ce_n/oe_n/we_n remain 1; wb_dat_o unchanged.
- Drop cyc during WAIT with wait_cfg=8: no ack; ce_n/oe_n=1 next edge; a following read completes normally.
- Assert wb_rst_i=0 mid-WAIT: outputs return to reset values asynchronously; wait_cfg reads back 4 afterwards.

Source files
------------

// File: rtl/flash_rom_ctrl.sv
// flash_rom_ctrl: Wishbone slave sequencing async NOR flash reads
// with programmable wait states, a bank register and two config regs.
module flash_rom_ctrl #(
  parameter logic [3:0] WAIT_DEFAULT = 4'd4,
  parameter logic [5:0] BANK_DEFAULT = 6'd0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [19:1] wb_adr_i,
  input  logic        wb_we_i,
  input  logic        wb_tga_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic [1:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic [21:0] flash_addr_,
  input  logic [15:0] flash_data_,
  output logic        flash_we_n_,
  output logic        flash_oe_n_,
  output logic        flash_ce_n_,
  output logic        flash_rst_n_
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_ACK
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  wait_q, wait_d;
  logic [5:0]  bank_q, bank_d;
  logic [15:0] dat_q, dat_d;
  logic [21:0] addr_q, addr_d;
  logic        ack_q, ack_d;
  logic        ce_n_q, ce_n_d;
  logic        frst_q;
  logic        req;
  logic        unused_ok;

  assign req = wb_stb_i & wb_cyc_i;

  // Upper address bits, high byte lane and high data bits never matter.
  assign unused_ok = ^{wb_adr_i[19:17], wb_sel_i[1], wb_dat_i[15:6]};

  // Next-state, config register updates and data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    bank_d  = bank_q;
    dat_d   = dat_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (wb_tga_i) begin
            state_d = S_ACK;
            if (wb_we_i) begin
              if (wb_sel_i[0]) begin
                if (wb_adr_i[1]) bank_d = wb_dat_i[5:0];
                else             wait_d = wb_dat_i[3:0];
              end
            end else begin
              dat_d = wb_adr_i[1] ? {10'h0, bank_q}
                                  : {12'h0, wait_q};
            end
          end else if (wb_we_i) begin
            state_d = S_ACK;
          end else begin
            state_d = S_SETUP;
            addr_d  = {bank_q, wb_adr_i[16:1]};
          end
        end
      end
      S_SETUP: begin
        if (!req) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = wait_q;
          if (wait_q != 4'd0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_ACK;
            dat_d   = flash_data_;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_ACK;
            dat_d   = flash_data_;
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ack_d  = (state_d == S_ACK);
    ce_n_d = !((state_d == S_SETUP) || (state_d == S_WAIT));
  end

  // State, config and registered output flops.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wait_q  <= WAIT_DEFAULT;
      bank_q  <= BANK_DEFAULT;
      dat_q   <= 16'h0;
      addr_q  <= 22'h0;
      ack_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      frst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      bank_q  <= bank_d;
      dat_q   <= dat_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      ce_n_q  <= ce_n_d;
      frst_q  <= 1'b1;
    end
  end

  assign wb_dat_o     = dat_q;
  assign wb_ack_o     = ack_q;
  assign flash_addr_  = addr_q;
  assign flash_ce_n_  = ce_n_q;
  assign flash_oe_n_  = ce_n_q;
  assign flash_we_n_  = 1'b1;
  assign flash_rst_n_ = frst_q;

endmodule
